// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, sync polarity type, pixel payload and sizing helpers for the LCD scanout.
package lcd_timing_pkg;

  localparam int unsigned LCD_H_ACTIVE = 480;
  localparam int unsigned LCD_H_FP     = 8;
  localparam int unsigned LCD_H_SYNC   = 4;
  localparam int unsigned LCD_H_BP     = 43;
  localparam int unsigned LCD_V_ACTIVE = 272;
  localparam int unsigned LCD_V_FP     = 8;
  localparam int unsigned LCD_V_SYNC   = 4;
  localparam int unsigned LCD_V_BP     = 12;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Clocks (or lines) in one full period: active + front porch + sync + back porch.
  function automatic int unsigned lcd_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed for a counter that runs 0 .. total-1.
  function automatic int unsigned lcd_cnt_width(input int unsigned total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/lcd_fifo_scanout_if.sv
// Read side of the PSRAM FIFO as seen by the scanout: data, empty flag and pop request.
interface lcd_fifo_scanout_if;
  logic [16:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rdreq;

  // master: the scanout, which pops; slave: the FIFO, which supplies data.
  modport master (input fifo_q, input fifo_empty, output fifo_rdreq);
  modport slave  (output fifo_q, output fifo_empty, input fifo_rdreq);
endinterface

// File: rtl/lcd_timing_gen.sv
// H/V counters for RGB panel timing, with start-up hold until the FIFO first has data.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LCD_H_ACTIVE,
  parameter int unsigned H_FP     = LCD_H_FP,
  parameter int unsigned H_SYNC   = LCD_H_SYNC,
  parameter int unsigned H_BP     = LCD_H_BP,
  parameter int unsigned V_ACTIVE = LCD_V_ACTIVE,
  parameter int unsigned V_FP     = LCD_V_FP,
  parameter int unsigned V_SYNC   = LCD_V_SYNC,
  parameter int unsigned V_BP     = LCD_V_BP
)(
  input  logic clk,
  input  logic reset,
  input  logic start_c,
  output logic act_c,
  output logic hsync_act_c,
  output logic vsync_act_c,
  output logic first_c
);

  localparam int unsigned H_TOTAL = lcd_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = lcd_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW = lcd_cnt_width(H_TOTAL);
  localparam int unsigned VW = lcd_cnt_width(V_TOTAL);
  localparam int unsigned HX = HW + 1;
  localparam int unsigned VX = VW + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Region bounds carry one spare bit so an end bound equal to the total cannot wrap.
  localparam logic [HX-1:0] H_ACT_END  = HX'(H_ACTIVE);
  localparam logic [HX-1:0] H_SYNC_BEG = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] H_SYNC_END = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] V_ACT_END  = VX'(V_ACTIVE);
  localparam logic [VX-1:0] V_SYNC_BEG = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] V_SYNC_END = VX'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] ST_WAIT_FILL = 1'b0;
  localparam logic [0:0] ST_RUN       = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HX-1:0] h_ext;
  logic [VX-1:0] v_ext;
  logic          run;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_WAIT_FILL;
    else       state <= state_nxt;
  end

  // Leave WAIT_FILL once the FIFO holds data; RUN is left only through reset.
  always_comb begin
    state_nxt = state;
    if (state == ST_WAIT_FILL && start_c) state_nxt = ST_RUN;
  end

  assign run = (state == ST_RUN);

  // Free-running pixel/line counters; held at zero until scanning starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  assign act_c       = run && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign hsync_act_c = run && (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
  assign vsync_act_c = run && (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
  assign first_c     = run && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/lcd_fifo_scanout.sv
// Pops RGB565 pixels from the read FIFO and drives an RGB panel with a fixed 2-clock pipeline.
module lcd_fifo_scanout
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = LCD_H_ACTIVE,
  parameter int unsigned H_FP      = LCD_H_FP,
  parameter int unsigned H_SYNC    = LCD_H_SYNC,
  parameter int unsigned H_BP      = LCD_H_BP,
  parameter int unsigned V_ACTIVE  = LCD_V_ACTIVE,
  parameter int unsigned V_FP      = LCD_V_FP,
  parameter int unsigned V_SYNC    = LCD_V_SYNC,
  parameter int unsigned V_BP      = LCD_V_BP,
  parameter sync_pol_e   HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter sync_pol_e   VSYNC_POL = SYNC_ACTIVE_LOW
)(
  input  logic                       clk,
  input  logic                       reset,
  lcd_fifo_scanout_if.master         fifo,
  input  logic                       underflow_clr,
  output logic                       lcd_de,
  output logic                       lcd_hsync,
  output logic                       lcd_vsync,
  output logic [4:0]                 lcd_r,
  output logic [5:0]                 lcd_g,
  output logic [4:0]                 lcd_b,
  output logic                       frame_start,
  output logic                       underflow
);

  localparam logic HS_ON  = 1'(HSYNC_POL);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = 1'(VSYNC_POL);
  localparam logic VS_OFF = ~VS_ON;

  logic    act_c;
  logic    hs_c;
  logic    vs_c;
  logic    first_c;
  logic    s1_act;
  logic    s1_pop;
  logic    s1_hs;
  logic    s1_vs;
  logic    s1_first;
  rgb565_t pix;
  logic    unused_fifo_q16;

  lcd_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .start_c     (~fifo.fifo_empty),
    .act_c       (act_c),
    .hsync_act_c (hs_c),
    .vsync_act_c (vs_c),
    .first_c     (first_c)
  );

  // Pop only for active pixels; an empty FIFO skips the pop instead of stalling the raster.
  assign fifo.fifo_rdreq = act_c & ~fifo.fifo_empty;

  // Bit 16 of the FIFO word carries nothing for the panel.
  assign unused_fifo_q16 = fifo.fifo_q[16];

  // Stage 1: capture the decode alongside the pop, whose data arrives next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_act   <= 1'b0;
      s1_pop   <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_first <= 1'b0;
    end else begin
      s1_act   <= act_c;
      s1_pop   <= fifo.fifo_rdreq;
      s1_hs    <= hs_c;
      s1_vs    <= vs_c;
      s1_first <= first_c;
    end
  end

  // Stage 2: panel pins; a pixel that missed its pop is driven black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= HS_OFF;
      lcd_vsync   <= VS_OFF;
      frame_start <= 1'b0;
      pix         <= '0;
    end else begin
      lcd_de      <= s1_act;
      lcd_hsync   <= s1_hs ? HS_ON : HS_OFF;
      lcd_vsync   <= s1_vs ? VS_ON : VS_OFF;
      frame_start <= s1_first;
      pix         <= s1_pop ? rgb565_t'(fifo.fifo_q[15:0]) : '0;
    end
  end

  // Sticky underflow, raised with the black pixel; a new underflow beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  underflow <= 1'b0;
    else if (s1_act && !s1_pop) underflow <= 1'b1;
    else if (underflow_clr)     underflow <= 1'b0;
  end

  assign lcd_r = pix.r;
  assign lcd_g = pix.g;
  assign lcd_b = pix.b;

endmodule

// File: tb/tb_lcd_fifo_scanout.sv
// Scoreboard bench for lcd_fifo_scanout on a tiny 7x5 raster with a queue-backed FIFO.
module tb_lcd_fifo_scanout;

  localparam int HA = 4, HF = 1, HS = 1, HB = 1;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       underflow_clr = 1'b0;
  logic       lcd_de, lcd_hsync, lcd_vsync, frame_start, underflow;
  logic [4:0] lcd_r;
  logic [5:0] lcd_g;
  logic [4:0] lcd_b;

  lcd_fifo_scanout_if fif();

  lcd_fifo_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo          (fif),
    .underflow_clr (underflow_clr),
    .lcd_de        (lcd_de),
    .lcd_hsync     (lcd_hsync),
    .lcd_vsync     (lcd_vsync),
    .lcd_r         (lcd_r),
    .lcd_g         (lcd_g),
    .lcd_b         (lcd_b),
    .frame_start   (frame_start),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // FIFO stand-in (fq) and the model's own copy of the pixel stream (mq).
  logic [15:0] fq[$];
  logic [15:0] mq[$];
  bit force_empty = 1'b1;
  bit feed = 1'b0;

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    mq.push_back(w);
  endtask

  // Normal-mode FIFO: word appears on q the cycle after rdreq; bit 16 is random junk.
  always @(posedge clk) begin
    if (fif.fifo_rdreq && fq.size() > 0) fif.fifo_q <= {1'($urandom), fq.pop_front()};
  end

  always @(negedge clk) begin
    if (feed && fq.size() < 4) push_word(16'($urandom));
    fif.fifo_empty = force_empty || (fq.size() == 0);
  end

  // Reference model: pixel slot t = cycles since scanning started, modulo one frame.
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        uf_set;
    logic [15:0] rgb;
  } slot_t;

  slot_t       pend = '0;
  bit          running = 1'b0;
  int          t = 0;
  logic        uf_m = 1'b0;
  logic [20:0] exp_q[$];

  function automatic bit in_act(input int tt);
    return ((tt % HT) < HA) && ((tt / HT) < VA);
  endfunction

  // Each edge: emit the pins due now (slot sampled one edge earlier), then sample the current slot.
  always @(posedge clk) begin
    if (reset) begin
      running = 1'b0;
      t = 0;
      pend = '0;
      uf_m = 1'b0;
      exp_q.delete();
    end else begin
      if (pend.uf_set) uf_m = 1'b1;
      else if (underflow_clr) uf_m = 1'b0;
      exp_q.push_back({pend.de, ~pend.hs, ~pend.vs, pend.fs, uf_m, pend.rgb});
      pend = '0;
      if (running) begin
        pend.de = in_act(t);
        pend.hs = ((t % HT) >= HA + HF) && ((t % HT) < HA + HF + HS);
        pend.vs = ((t / HT) >= VA + VF) && ((t / HT) < VA + VF + VS);
        pend.fs = (t == 0);
        if (pend.de) begin
          if (!fif.fifo_empty && mq.size() > 0) pend.rgb = mq.pop_front();
          else pend.uf_set = 1'b1;
        end
        t = (t + 1) % FRAME;
      end else if (!fif.fifo_empty) begin
        running = 1'b1;
        t = 0;
      end
    end
  end

  // Monitor: compare pins against the scoreboard and rdreq against the current slot.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0)
        check("pins", 32'({lcd_de, lcd_hsync, lcd_vsync, frame_start, underflow, lcd_r, lcd_g, lcd_b}),
              32'(exp_q.pop_front()));
      check("rdreq", 32'(fif.fifo_rdreq), 32'(running && in_act(t) && !fif.fifo_empty));
    end
  end

  task automatic check_reset(input string name);
    check({name, "_pins"}, 32'({lcd_de, lcd_hsync, lcd_vsync, frame_start, underflow, lcd_r, lcd_g, lcd_b}),
          32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}));
    check({name, "_rdreq"}, 32'(fif.fifo_rdreq), 32'(0));
  endtask

  task automatic wait_slot(input int target);
    bit hit = 1'b0;
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      @(posedge clk); #2;
      hit = running && (t == target);
    end
    check("slot_reached", 32'(hit), 32'(1));
  endtask

  initial begin
    int  first_rd, first_de, rd_hi, de_hi, hs_lo, vs_lo;
    bit  found;

    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    @(negedge clk);
    reset = 1'b0;

    // Empty FIFO: nothing may start.
    rd_hi = 0; de_hi = 0; hs_lo = 0;
    repeat (100) begin
      @(negedge clk); #2;
      rd_hi += int'(fif.fifo_rdreq);
      de_hi += int'(lcd_de);
      hs_lo += int'(!lcd_hsync);
    end
    check("idle_rdreq", 32'(rd_hi), 32'(0));
    check("idle_de", 32'(de_hi), 32'(0));
    check("idle_hsync", 32'(hs_lo), 32'(0));

    // Preload 1..8, then keep the FIFO topped up.
    @(posedge clk); #2;
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    force_empty = 1'b0;
    feed = 1'b1;
    first_rd = -1; first_de = -1;
    for (int c = 0; c < 40 && first_de < 0; c++) begin
      @(negedge clk); #2;
      if (first_rd < 0 && fif.fifo_rdreq) first_rd = c;
      if (lcd_de) begin
        first_de = c;
        check("de_latency", 32'(c - first_rd), 32'(2));
        check("first_pixel", 32'({lcd_r, lcd_g, lcd_b}), 32'(1));
        check("first_frame_start", 32'(frame_start), 32'(1));
      end
    end
    check("de_seen", 32'(first_de >= 0), 32'(1));

    // Free-run window of one frame.
    rd_hi = 0; de_hi = 0; hs_lo = 0; vs_lo = 0;
    repeat (FRAME) begin
      @(negedge clk); #2;
      rd_hi += int'(fif.fifo_rdreq);
      de_hi += int'(lcd_de);
      hs_lo += int'(!lcd_hsync);
      vs_lo += int'(!lcd_vsync);
    end
    check("frame_hsync_low", 32'(hs_lo), 32'(VT * HS));
    check("frame_vsync_low", 32'(vs_lo), 32'(VS * HT));
    check("frame_de", 32'(de_hi), 32'(HA * VA));
    check("frame_rdreq", 32'(rd_hi), 32'(HA * VA));

    // Starve pixel 2 of line 0.
    wait_slot(2);
    force_empty = 1'b1;
    @(posedge clk); #2;
    force_empty = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("uf_set", 32'(underflow), 32'(1));
    repeat (FRAME) @(posedge clk);
    #2;
    check("uf_sticky", 32'(underflow), 32'(1));
    underflow_clr = 1'b1;
    @(posedge clk); #2;
    underflow_clr = 1'b0;
    check("uf_clr", 32'(underflow), 32'(0));

    // Clear held across a new underflow: set must win.
    wait_slot(2);
    force_empty = 1'b1;
    underflow_clr = 1'b1;
    @(posedge clk); #2;
    force_empty = 1'b0;
    @(posedge clk); #2;
    underflow_clr = 1'b0;
    check("uf_set_wins", 32'(underflow), 32'(1));

    // Random starvation and clears.
    repeat (300) begin
      @(posedge clk); #2;
      force_empty = ($urandom_range(7) == 0);
      underflow_clr = ($urandom_range(15) == 0);
    end
    @(posedge clk); #2;
    force_empty = 1'b0;
    underflow_clr = 1'b0;

    // Reset mid-line while DE is high.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(posedge clk); #2;
      found = lcd_de;
    end
    check("de_before_reset", 32'(found), 32'(1));
    reset = 1'b1;
    force_empty = 1'b1;
    #1;
    check_reset("mid_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    force_empty = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #2;
      if (lcd_de) begin
        found = 1'b1;
        check("restart_frame_start", 32'(frame_start), 32'(1));
      end
    end
    check("restart_de_seen", 32'(found), 32'(1));
    repeat (2 * FRAME) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_fifo_scanout.md
Name: lcd_fifo_scanout

Overview:
Downstream consumer of the PSRAM read FIFO. It runs on the FIFO read clock, which is also the LCD pixel clock. It generates RGB-panel timing (HSYNC/VSYNC/DE), pops one 16-bit RGB565 word per active pixel, and drives the panel pins. It holds off scanning until the FIFO first holds data, then runs free-running frames. Any underflow is flagged, and black is output for the affected pixel.

Parameters:
H_ACTIVE, 480, visible pixels per line
H_FP, 8, horizontal front porch (clocks)
H_SYNC, 4, HSYNC width (clocks)
H_BP, 43, horizontal back porch (clocks)
V_ACTIVE, 272, visible lines per frame
V_FP, 8, vertical front porch (lines)
V_SYNC, 4, VSYNC width (lines)
V_BP, 12, vertical back porch (lines)
HSYNC_POL, 0, HSYNC asserted level (0 = active-low)
VSYNC_POL, 0, VSYNC asserted level (0 = active-low)

Ports:
clk  in  1  pixel clock, same clock as the FIFO read side
reset  in  1  asynchronous, active-high
fifo_q  in  17  FIFO read data; [15:0] is RGB565, [16] is ignored
fifo_empty  in  1  FIFO read-side empty
fifo_rdreq  out  1  FIFO pop request (normal mode: data valid the cycle after rdreq)
lcd_de  out  1  data enable
lcd_hsync  out  1  horizontal sync
lcd_vsync  out  1  vertical sync
lcd_r  out  5  red = fifo_q[15:11]
lcd_g  out  6  green = fifo_q[10:5]
lcd_b  out  5  blue = fifo_q[4:0]
frame_start  out  1  one-clock pulse, aligned with the first DE of each frame
underflow  out  1  sticky; set when an active pixel finds the FIFO empty
underflow_clr  in  1  synchronous clear of underflow (set wins if both occur in the same cycle)

Behaviour:
- Clock and reset are fixed: reset is asynchronous and active-high; the clock is clk.
- Reset values:
  - lcd_de = 0, fifo_rdreq = 0, frame_start = 0, underflow = 0.
  - lcd_r/g/b = 0.
  - lcd_hsync = ~HSYNC_POL, lcd_vsync = ~VSYNC_POL.
  - Counters h_cnt = 0, v_cnt = 0; state = WAIT_FILL.
- Totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Counters are wide enough for the totals; no truncation.
- State machine:
  - WAIT_FILL: counters held at 0, outputs held at their reset values. Move to RUN on the first cycle with fifo_empty = 0.
  - RUN: h_cnt increments every clock and wraps H_TOTAL-1 -> 0. On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0. RUN never returns to WAIT_FILL except through reset.
- Region order within a line: active [0, H_ACTIVE), then front porch, then sync, then back porch. Lines follow the same order vertically. Vertical sync asserts for whole lines.
- Stage 0 (combinational, from counters):
  - act = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE, in RUN.
  - fifo_rdreq = act and not fifo_empty.
- Stage 1 (registered): act, the pop flag, the syncs, and a first-pixel flag (h = 0, v = 0).
- Stage 2 (registered, drives the pins):
  - lcd_de = act.
  - lcd_r/g/b = fifo_q[15:0] if the pop flag is set, else 0.
  - Syncs and frame_start are delayed to match.
- Latency: counter-to-pin is exactly 2 clocks for all outputs. DE, syncs and data stay mutually aligned.
- Underflow: an active pixel with fifo_empty = 1 does not pop, outputs 0 with DE = 1, and sets underflow in the stage-2 cycle. Scanning never stalls; line and frame timing are invariant.
- No pops occur outside the active region, even when the FIFO holds data.
- Reset mid-frame: all state returns to WAIT_FILL immediately. FIFO contents are not flushed by this block.

Decomposition:
- Package lcd_timing_pkg holds:
  - default timing constants (480x272 set above);
  - a polarity enum;
  - a helper function computing totals and counter width.
- Sub-module lcd_timing_gen holds the h/v counters, the region decode and the act/sync/first-pixel outputs. The top adds the pop logic, the 2-stage pipeline and the underflow flag.

Test Plan:
- Reset, FIFO empty for 100 clocks, with H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 -> no rdreq, DE = 0, syncs inactive (1), RGB = 0.
- Same parameters, FIFO preloaded with 0x0001..0x0008, fifo_empty deasserts:
  - rdreq is high 4 clocks per active line;
  - DE rises 2 clocks after the first rdreq;
  - pins show 0x0001..0x0004 then 0x0005..0x0008;
  - frame_start pulses with the pixel 0x0001.
- Free-run with the FIFO always non-empty:
  - HSYNC is low exactly 1 clock per 7-clock line;
  - VSYNC is low exactly 7 clocks per 35-clock frame;
  - DE is high 8 clocks per frame.
- FIFO goes empty for pixel 2 of line 0 -> that pixel shows RGB 0 with DE = 1, underflow = 1 from then on, next-frame timing unchanged; underflow_clr then clears it.
- underflow_clr and a new underflow in the same cycle -> underflow stays 1.
- Assert reset mid-line with DE = 1 -> all outputs at reset values the same cycle; scanning waits for non-empty, then restarts at h = 0, v = 0.
